// File: rtl/dsram_wbuf_resp.sv
// Data-SRAM responder with a posted write buffer in front of a shared,
// arbitrated single-port memory. Loads take one cycle, with bytes forwarded
// from undrained stores; stores are queued and drained whenever no load
// needs the memory port.
module dsram_wbuf_resp #(
    parameter int DEPTH = 4,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          data_sram_en,
    input  logic [3:0]    data_sram_wen,
    input  logic [31:0]   data_sram_addr,
    input  logic [31:0]   data_sram_wdata,
    output logic [31:0]   data_sram_rdata,
    output logic          stallreq_for_mem,
    output logic          mem_req,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_gnt,
    input  logic [31:0]   mem_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Overlay the enabled bytes of fwd onto base.
    function automatic logic [31:0] merge_bytes(input logic [3:0]  mask,
                                                input logic [31:0] fwd,
                                                input logic [31:0] base);
        logic [31:0] r;
        r = base;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) r[8*b +: 8] = fwd[8*b +: 8];
        end
        return r;
    endfunction

    // Write-buffer storage (data only; validity is implied by the pointers).
    logic [AW-1:0] buf_addr [DEPTH];
    logic [3:0]    buf_be   [DEPTH];
    logic [31:0]   buf_data [DEPTH];

    // Buffer control.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Request decode, stage 0.
    logic [AW-1:0] req_addr_p0;
    logic          load_p0;
    logic          store_p0;
    logic          drain_p0;
    logic          full;
    logic          push;
    logic          pop;
    logic          ld_acc_p0;
    logic [3:0]    fwd_mask_p0;
    logic [31:0]   fwd_data_p0;
    logic [PW-1:0] idx;

    // Load result, stage 1.
    logic          vld_p1;
    logic [3:0]    fwd_mask_p1;
    logic [31:0]   fwd_data_p1;

    // Address bits outside the word address are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{data_sram_addr[31:AW+2], data_sram_addr[1:0]};

    assign req_addr_p0 = data_sram_addr[AW+1:2];

    // ---- stage 0: classify request and decide push / pop / accept ----
    // Loads own the memory port; a drain only runs when no load is present.
    always_comb begin
        load_p0   = data_sram_en && (data_sram_wen == 4'b0000);
        store_p0  = data_sram_en && (data_sram_wen != 4'b0000);
        full      = (count == CW'(DEPTH));
        drain_p0  = !load_p0 && (count != '0);
        push      = store_p0 && !full;
        pop       = drain_p0 && mem_gnt;
        ld_acc_p0 = load_p0 && mem_gnt;
    end

    // Drive the memory port and the stall request; everything is quiet in reset.
    always_comb begin
        mem_req          = 1'b0;
        mem_we           = 4'b0000;
        mem_addr         = '0;
        mem_wdata        = 32'h0;
        stallreq_for_mem = 1'b0;
        if (!rst) begin
            if (load_p0) begin
                mem_req  = 1'b1;
                mem_addr = req_addr_p0;
            end else if (drain_p0) begin
                mem_req   = 1'b1;
                mem_we    = buf_be[rd_ptr];
                mem_addr  = buf_addr[rd_ptr];
                mem_wdata = buf_data[rd_ptr];
            end
            // A full buffer stalls a store even if the oldest entry drains now.
            stallreq_for_mem = (load_p0 && !mem_gnt) || (store_p0 && full);
        end
    end

    // Walk the buffer oldest to newest so the newest matching store wins per byte.
    always_comb begin
        fwd_mask_p0 = 4'b0000;
        fwd_data_p0 = 32'h0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) && (buf_addr[idx] == req_addr_p0)) begin
                fwd_mask_p0 = fwd_mask_p0 | buf_be[idx];
                fwd_data_p0 = merge_bytes(buf_be[idx], buf_data[idx], fwd_data_p0);
            end
        end
    end

    // Pointer, occupancy and read-pending control; reset discards buffered stores.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count  <= count + CW'(push) - CW'(pop);
            vld_p1 <= ld_acc_p0;
        end
    end

    // ---- stage 0 -> stage 1: buffer writes and forward capture ----
    // Buffer contents and the forward snapshot need no reset; validity lives in control.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= req_addr_p0;
            buf_be[wr_ptr]   <= data_sram_wen;
            buf_data[wr_ptr] <= data_sram_wdata;
        end
        if (ld_acc_p0) begin
            fwd_mask_p1 <= fwd_mask_p0;
            fwd_data_p1 <= fwd_data_p0;
        end
    end

    // ---- stage 1: merge forwarded bytes over the memory read data ----
    // Returns zero whenever no load result is due.
    always_comb begin
        data_sram_rdata = 32'h0;
        if (vld_p1 && !rst) begin
            data_sram_rdata = merge_bytes(fwd_mask_p1, fwd_data_p1, mem_rdata);
        end
    end

endmodule

// File: tb/tb_dsram_wbuf_resp.sv
// Bench for dsram_wbuf_resp: a directed vector table for the basic cases,
// hand sequences for the multi-cycle corners, and a randomized run against a
// queue-based model of "memory plus pending stores".
module tb_dsram_wbuf_resp;

    localparam int DEPTH = 4;
    localparam int AW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          data_sram_en;
    logic [3:0]    data_sram_wen;
    logic [31:0]   data_sram_addr;
    logic [31:0]   data_sram_wdata;
    logic [31:0]   data_sram_rdata;
    logic          stallreq_for_mem;
    logic          mem_req;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_gnt;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    dsram_wbuf_resp #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .data_sram_en     (data_sram_en),
        .data_sram_wen    (data_sram_wen),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .data_sram_rdata  (data_sram_rdata),
        .stallreq_for_mem (stallreq_for_mem),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_gnt          (mem_gnt),
        .mem_rdata        (mem_rdata)
    );

    typedef struct {
        logic [31:0] en, wen, addr, wdata, gnt;
        logic [31:0] e_req, e_we, e_addr, e_wdata, e_stall, e_rdata;
    } vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   d;
    } st_t;

    vec_t        tbl[$];
    st_t         wq[$];
    logic        pend_v = 1'b0;
    logic [31:0] pend_d = 32'h0;
    logic [31:0] bmem    [0:65535];
    logic [31:0] ref_mem [0:65535];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;

    function automatic logic [31:0] init_word(input int i);
        logic [15:0] lo;
        lo = 16'(i);
        return {lo, ~lo};
    endfunction

    function automatic logic [31:0] put_bytes(input logic [31:0] old, input logic [3:0] be,
                                              input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // What a load must see: memory image with every pending store applied in order.
    function automatic logic [31:0] visible_word(input logic [AW-1:0] a);
        logic [31:0] w;
        w = ref_mem[a];
        foreach (wq[k]) if (wq[k].a == a) w = put_bytes(w, wq[k].be, wq[k].d);
        return w;
    endfunction

    function automatic vec_t mk(input logic [31:0] en, wen, addr, wdata, gnt,
                                input logic [31:0] e_req, e_we, e_addr, e_wdata, e_stall, e_rdata);
        vec_t v;
        v.en = en; v.wen = wen; v.addr = addr; v.wdata = wdata; v.gnt = gnt;
        v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_stall = e_stall; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    endtask

    task automatic mem_init();
        for (int i = 0; i < 65536; i++) begin
            bmem[i]    = init_word(i);
            ref_mem[i] = bmem[i];
        end
        bmem[16'h40]    = 32'hAABBCCDD;
        ref_mem[16'h40] = 32'hAABBCCDD;
    endtask

    // Backing memory: sample the port before the edge, respond just after it.
    task automatic finish_cycle();
        logic          c_req, c_gnt;
        logic [3:0]    c_we;
        logic [AW-1:0] c_addr;
        logic [31:0]   c_wd;
        c_req = mem_req; c_gnt = mem_gnt; c_we = mem_we; c_addr = mem_addr; c_wd = mem_wdata;
        @(posedge clk);
        #1;
        if (c_req && c_gnt) begin
            if (c_we == 4'b0000) mem_rdata = bmem[c_addr];
            else bmem[c_addr] = put_bytes(bmem[c_addr], c_we, c_wd);
        end
        cyc++;
    endtask

    // One model-checked cycle; 'stalled' returns the DUT's stall output.
    task automatic step(input logic [31:0] en, wen, addr, wdata, gnt, output logic stalled);
        logic          ld, st, dr, e_stall;
        logic [AW-1:0] wa;
        logic [31:0]   e_rd;
        st_t           e;
        data_sram_en = en[0]; data_sram_wen = wen[3:0]; data_sram_addr = addr;
        data_sram_wdata = wdata; mem_gnt = gnt[0];
        ld = en[0] && (wen[3:0] == 4'b0000);
        st = en[0] && (wen[3:0] != 4'b0000);
        dr = !ld && (wq.size() > 0);
        wa = addr[AW+1:2];
        e_stall = (ld && !gnt[0]) || (st && (wq.size() == DEPTH));
        e_rd = pend_v ? pend_d : 32'h0;
        @(negedge clk);
        chk($sformatf("stall@%0d", cyc), 32'(stallreq_for_mem), 32'(e_stall));
        chk($sformatf("req@%0d", cyc), 32'(mem_req), 32'(ld || dr));
        chk($sformatf("rdata@%0d", cyc), data_sram_rdata, e_rd);
        if (ld) begin
            chk($sformatf("ld_we@%0d", cyc), 32'(mem_we), 32'h0);
            chk($sformatf("ld_addr@%0d", cyc), 32'(mem_addr), 32'(wa));
        end else if (dr) begin
            chk($sformatf("dr_we@%0d", cyc), 32'(mem_we), 32'(wq[0].be));
            chk($sformatf("dr_addr@%0d", cyc), 32'(mem_addr), 32'(wq[0].a));
            chk($sformatf("dr_wdata@%0d", cyc), mem_wdata, wq[0].d);
        end else begin
            chk($sformatf("idle_we@%0d", cyc), 32'(mem_we), 32'h0);
        end
        stalled = stallreq_for_mem;
        pend_v = ld && gnt[0];
        if (pend_v) pend_d = visible_word(wa);
        if (dr && gnt[0]) begin
            ref_mem[wq[0].a] = put_bytes(ref_mem[wq[0].a], wq[0].be, wq[0].d);
            void'(wq.pop_front());
        end
        if (st && !e_stall) begin
            e.a = wa; e.be = wen[3:0]; e.d = wdata;
            wq.push_back(e);
        end
        finish_cycle();
    endtask

    task automatic drain_all();
        logic s;
        for (int k = 0; k < DEPTH + 4; k++) step(0, 0, 0, 0, 1, s);
    endtask

    task automatic cmp_mem(input int lo, input int hi, input string tag);
        for (int a = lo; a <= hi; a++)
            chk($sformatf("%s_mem[%0h]", tag, a), bmem[a], ref_mem[a]);
    endtask

    initial begin
        logic        s;
        logic [31:0] r_en, r_wen, r_addr, r_wd, r_gnt;

        rst = 1'b0;
        data_sram_en = 1'b0; data_sram_wen = 4'b0; data_sram_addr = 32'h0;
        data_sram_wdata = 32'h0; mem_gnt = 1'b0; mem_rdata = 32'h0;
        mem_init();

        //        en wen  addr    wdata        gnt req we  maddr  mwdata       stall rdata
        tbl.push_back(mk(1, 0,  'h100, 0,           1, 1, 0,  'h40, 0,           0, 0));
        tbl.push_back(mk(0, 0,  0,     0,           0, 0, 0,  0,    0,           0, 'hAABBCCDD));
        tbl.push_back(mk(0, 0,  0,     0,           0, 0, 0,  0,    0,           0, 0));
        tbl.push_back(mk(1, 3,  'h100, 'h1234,      0, 0, 0,  0,    0,           0, 0));
        tbl.push_back(mk(1, 0,  'h100, 0,           1, 1, 0,  'h40, 0,           0, 0));
        tbl.push_back(mk(0, 0,  0,     0,           0, 1, 3,  'h40, 'h1234,      0, 'hAABB1234));
        tbl.push_back(mk(1, 1,  'h100, 'h11,        0, 1, 3,  'h40, 'h1234,      0, 0));
        tbl.push_back(mk(1, 1,  'h100, 'h22,        0, 1, 3,  'h40, 'h1234,      0, 0));
        tbl.push_back(mk(1, 0,  'h100, 0,           1, 1, 0,  'h40, 0,           0, 0));
        tbl.push_back(mk(0, 0,  0,     0,           1, 1, 3,  'h40, 'h1234,      0, 'hAABB1222));
        tbl.push_back(mk(0, 0,  0,     0,           1, 1, 1,  'h40, 'h11,        0, 0));
        tbl.push_back(mk(0, 0,  0,     0,           1, 1, 1,  'h40, 'h22,        0, 0));
        tbl.push_back(mk(0, 0,  0,     0,           0, 0, 0,  0,    0,           0, 0));
        tbl.push_back(mk(1, 15, 'h200, 'h01010101,  0, 0, 0,  0,    0,           0, 0));
        tbl.push_back(mk(1, 15, 'h204, 'h02020202,  0, 1, 15, 'h80, 'h01010101,  0, 0));
        tbl.push_back(mk(1, 1,  'h208, 'h03030303,  0, 1, 15, 'h80, 'h01010101,  0, 0));
        tbl.push_back(mk(1, 8,  'h20C, 'h04040404,  0, 1, 15, 'h80, 'h01010101,  0, 0));
        tbl.push_back(mk(1, 15, 'h210, 'h05050505,  0, 1, 15, 'h80, 'h01010101,  1, 0));
        tbl.push_back(mk(1, 15, 'h210, 'h05050505,  0, 1, 15, 'h80, 'h01010101,  1, 0));
        tbl.push_back(mk(1, 15, 'h210, 'h05050505,  1, 1, 15, 'h80, 'h01010101,  1, 0));
        tbl.push_back(mk(1, 15, 'h210, 'h05050505,  1, 1, 15, 'h81, 'h02020202,  0, 0));
        tbl.push_back(mk(0, 0,  0,     0,           1, 1, 1,  'h82, 'h03030303,  0, 0));
        tbl.push_back(mk(0, 0,  0,     0,           1, 1, 8,  'h83, 'h04040404,  0, 0));
        tbl.push_back(mk(0, 0,  0,     0,           1, 1, 15, 'h84, 'h05050505,  0, 0));
        tbl.push_back(mk(0, 0,  0,     0,           1, 0, 0,  0,    0,           0, 0));
        tbl.push_back(mk(1, 0,  'h104, 0,           0, 1, 0,  'h41, 0,           1, 0));
        tbl.push_back(mk(1, 0,  'h104, 0,           0, 1, 0,  'h41, 0,           1, 0));
        tbl.push_back(mk(1, 0,  'h104, 0,           0, 1, 0,  'h41, 0,           1, 0));
        tbl.push_back(mk(1, 0,  'h104, 0,           1, 1, 0,  'h41, 0,           0, 0));
        tbl.push_back(mk(0, 0,  0,     0,           0, 0, 0,  0,    0,           0, 'h0041FFBE));
        tbl.push_back(mk(0, 0,  0,     0,           0, 0, 0,  0,    0,           0, 0));

        // Reset with a would-stall load present: all outputs must stay low.
        #1 rst = 1'b1;
        data_sram_en = 1'b1; data_sram_addr = 32'h100; mem_gnt = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_stall", 32'(stallreq_for_mem), 32'h0);
        chk("rst_rdata", data_sram_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        data_sram_en = 1'b0;

        // Directed vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            data_sram_en = tbl[i].en[0]; data_sram_wen = tbl[i].wen[3:0];
            data_sram_addr = tbl[i].addr; data_sram_wdata = tbl[i].wdata;
            mem_gnt = tbl[i].gnt[0];
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(stallreq_for_mem), tbl[i].e_stall);
            chk($sformatf("v%0d_req", i), 32'(mem_req), tbl[i].e_req);
            chk($sformatf("v%0d_rdata", i), data_sram_rdata, tbl[i].e_rdata);
            if (tbl[i].e_req[0]) begin
                chk($sformatf("v%0d_we", i), 32'(mem_we), tbl[i].e_we);
                chk($sformatf("v%0d_addr", i), 32'(mem_addr), tbl[i].e_addr);
                if (tbl[i].e_we != 0) chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].e_wdata);
            end
            finish_cycle();
        end
        chk("vmem_40", bmem[16'h40], 32'hAABB1222);
        chk("vmem_80", bmem[16'h80], 32'h01010101);
        chk("vmem_81", bmem[16'h81], 32'h02020202);
        chk("vmem_82", bmem[16'h82], 32'h0082FF03);
        chk("vmem_83", bmem[16'h83], 32'h0483FF7C);
        chk("vmem_84", bmem[16'h84], 32'h05050505);

        // Same-cycle push and pop with two entries keeps occupancy at two.
        mem_init();
        step(1, 15, 'h180, 'hA1A1A1A1, 0, s);
        step(1, 15, 'h184, 'hB2B2B2B2, 0, s);
        step(1, 3,  'h188, 'hC3C3C3C3, 1, s);
        chk("t5_pushpop_accept", 32'(s), 32'h0);
        step(1, 15, 'h18C, 'hD4D4D4D4, 0, s);
        chk("t5_third_accept", 32'(s), 32'h0);
        step(1, 15, 'h190, 'hE5E5E5E5, 0, s);
        chk("t5_fourth_accept", 32'(s), 32'h0);
        step(1, 15, 'h194, 'hF6F6F6F6, 0, s);
        chk("t5_full_stall", 32'(s), 32'h1);
        step(1, 15, 'h194, 'hF6F6F6F6, 1, s);
        chk("t5_full_drain_still_stall", 32'(s), 32'h1);
        step(1, 15, 'h194, 'hF6F6F6F6, 1, s);
        chk("t5_retry_accept", 32'(s), 32'h0);
        drain_all();
        cmp_mem('h60, 'h65, "t5");

        // Pointer wrap: ten store/drain pairs, then read everything back.
        for (int i = 0; i < 10; i++)
            step(1, $urandom_range(1, 15), 32'h1A0 + 32'(4 * (i % 4)), $urandom, 1, s);
        drain_all();
        cmp_mem('h68, 'h6B, "wrap");
        for (int i = 0; i < 4; i++) step(1, 0, 32'h1A0 + 32'(4 * i), 0, 1, s);
        step(0, 0, 0, 0, 0, s);

        // Randomized traffic; a stalled request is re-presented unchanged.
        s = 1'b0;
        r_en = 0; r_wen = 0; r_addr = 0; r_wd = 0;
        for (int i = 0; i < 400; i++) begin
            if (!s) begin
                r_en = ($urandom_range(0, 9) < 7) ? 1 : 0;
                r_wen = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 15);
                r_addr = 32'h180 + 32'(4 * $urandom_range(0, 3));
                r_wd = $urandom;
            end
            r_gnt = ($urandom_range(0, 9) < 6) ? 1 : 0;
            step(r_en, r_wen, r_addr, r_wd, r_gnt, s);
        end
        drain_all();
        cmp_mem('h60, 'h63, "rand");

        // Reset while draining three entries: outputs drop at once, stores are lost.
        step(1, 15, 'h300, 'h11111111, 0, s);
        step(1, 15, 'h304, 'h22222222, 0, s);
        step(1, 15, 'h308, 'h33333333, 0, s);
        data_sram_en = 1'b0; data_sram_wen = 4'b0; mem_gnt = 1'b0;
        #1;
        chk("t6_drain_active", 32'(mem_req), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_req", 32'(mem_req), 32'h0);
        chk("t6_rst_stall", 32'(stallreq_for_mem), 32'h0);
        chk("t6_rst_we", 32'(mem_we), 32'h0);
        chk("t6_rst_rdata", data_sram_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wq.delete();
        pend_v = 1'b0;
        step(1, 0, 'h300, 0, 1, s);
        step(0, 0, 0, 0, 0, s);
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 15, 32'h300 + 32'(4 * i), 32'h5A000000 + 32'(i), 0, s);
            chk($sformatf("t6_empty_accept%0d", i), 32'(s), 32'h0);
        end
        step(1, 15, 'h310, 'h5A0000FF, 0, s);
        chk("t6_full_after_reset", 32'(s), 32'h1);
        drain_all();
        cmp_mem('hC0, 'hC4, "t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
